clock_period_meter: RTL
=======================

Name: clock_period_meter

Overview:
- Measures an incoming divided or slow clock (`meas_clk`) in units of the system `clock`.
- Reports period and high time as cycle counts per input period, for checking divider outputs (power-of-2, odd, 50%/33% duty) in-system.
- Result is held in output registers with a valid/ack handshake.
- Detects a stuck input clock and result overruns.

Parameters:
- CNT_W, 16, width of the period/high-time counters and results; saturation point is 2^CNT_W-1.
- SYNC_STAGES, 2, flip-flop stages synchronising `meas_clk` into the `clock` domain; legal values are ≥2.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset), applied on its falling edge without waiting for `clock`.
- enable  in  1  1 = measure; 0 = return to IDLE and clear measurement counters.
- meas_clk  in  1  clock under test; asynchronous to `clock`.
- meas_ack  in  1  single-cycle pulse that consumes the current result.
- period  out  CNT_W  cycles between successive rising edges.
- high_time  out  CNT_W  cycles from a rising edge to the following falling edge.
- meas_valid  out  1  result pending; held until acknowledged.
- overrun  out  1  sticky: a result was overwritten while still pending.
- stuck  out  1  sticky: no edge seen within 2^CNT_W-1 cycles.

Behaviour:
- Reset (rst=0): `period`=0, `high_time`=0, `meas_valid`=0, `overrun`=0, `stuck`=0, synchroniser=0, counter=0, FSM=IDLE.
- Synchroniser: SYNC_STAGES flops, then one edge-detect flop.
  - `rise` = synced & ~prev; `fall` = ~synced & prev.
  - `rise`/`fall` assert SYNC_STAGES+1 cycles after the `meas_clk` transition.
- Counter `cnt`:
  - loads 1 on the `rise` cycle, otherwise increments each cycle;
  - saturates at 2^CNT_W-1.
  - With a rise at cycle 0, `cnt`=k in cycle k, so a divide-by-N input captures N.
- FSM states:
  - IDLE: `enable`=0. Counters held at 0; outputs and flags retain their values.
  - ARM: `enable`=1; waiting for the first `rise` (first partial period discarded). On `rise` → HIGH; `cnt`:=1.
  - HIGH: on `fall`, `hi_lat` := `cnt` → LOW.
  - LOW: on `rise` → HIGH (see capture rules).
- Any state: `enable`=0 → IDLE next cycle.
- Capture on `rise` in LOW:
  - `period` := `cnt`, `high_time` := `hi_lat`, `meas_valid` := 1, all in the same cycle;
  - then `cnt`:=1 and the next measurement starts immediately (no dead period).
  - `meas_valid` rises 1 cycle after the `rise` cycle.
- Handshake:
  - `meas_ack` while `meas_valid`=1 → `meas_valid`=0 next cycle.
  - `meas_ack` while `meas_valid`=0 is ignored.
- Capture while `meas_valid`=1 and no ack that cycle: outputs overwritten, `overrun` := 1.
- Capture and ack in the same cycle: the new result wins, `meas_valid` stays 1, `overrun` unchanged.
- Stuck detection: in HIGH, LOW or ARM, if `cnt` reaches 2^CNT_W-1 → `stuck` := 1, FSM → ARM, `cnt` := 0, no capture.
  - In ARM, `cnt` increments from 0 so a stuck input is also flagged there.
- Clearing sticky flags: `overrun` and `stuck` clear only on reset or on an `enable` 0→1 transition.
- `high_time` < `period` always holds for a valid capture.
  - Input pulses narrower than one `clock` period may be missed; this is not flagged.
- `rst` asserted mid-measurement: all state returns to reset values immediately.
  - After release: ARM if `enable`=1; the first period after reset is never reported.

Test Plan:
- `meas_clk` = `clock`/8, 50% duty, from a counter on the same `clock` → `period`=8, `high_time`=4; `meas_valid` every 8 cycles, acked each time, `overrun`=0.
- `meas_clk` = divide-by-3 rotating one-hot, 33% duty → `period`=3, `high_time`=1; `meas_ack` withheld after the first capture → `overrun`=1 on the second capture, `meas_valid` stays 1.
- `clock` 10 ns; async `meas_clk` 1 µs period, 300 ns high, random phase → `period` ∈ {99,100,101}, `high_time` ∈ {29,30,31}; first partial period never reported.
- CNT_W=8; `meas_clk` held low after one rise → `stuck`=1 exactly 255 cycles after that `rise`, FSM in ARM; toggle `enable` 0→1 → `stuck`=0.
- `rst` pulsed low mid-HIGH with `meas_valid`=1 → all outputs 0 immediately (no `clock` edge); first valid arrives only after two rises post-release.
- Capture and `meas_ack` forced into the same cycle → `meas_valid` stays 1 with the new `period`, `overrun` unchanged.

Source files
------------

// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
// clock_period_meter: measures period and high time of a slow/divided clock in system-clock
// cycles, holding each result behind a valid/ack handshake with sticky stuck/overrun flags.
module clock_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             meas_clk,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overrun,
    output logic             stuck
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi_lat;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_stuck;
    logic                   r_enable_d;

    logic                   w_synced;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_limit;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_synced & ~r_prev;
    assign w_fall    = ~w_synced & r_prev;
    assign w_cnt_inc = sat_inc(r_cnt);
    // Stuck fires on the cycle the count would reach the saturation value.
    assign w_limit   = (w_cnt_inc == CNT_MAX);

    // Synchroniser chain and edge-detect flop for the clock under test.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], meas_clk};
            r_prev <= w_synced;
        end
    end

    // Measurement FSM, counter, result registers and sticky flags.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_hi_lat    <= CNT_ZERO;
            r_period    <= CNT_ZERO;
            r_high_time <= CNT_ZERO;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_stuck     <= 1'b0;
            r_enable_d  <= 1'b0;
        end else begin
            r_enable_d <= enable;
            if (meas_ack && r_valid) begin
                r_valid <= 1'b0;
            end
            if (enable && !r_enable_d) begin
                r_overrun <= 1'b0;
                r_stuck   <= 1'b0;
            end
            if (!enable) begin
                r_state <= ST_IDLE;
                r_cnt   <= CNT_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                        r_cnt   <= CNT_ZERO;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= CNT_ONE;
                        end else if (w_limit) begin
                            r_stuck <= 1'b1;
                            r_cnt   <= CNT_ZERO;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_HIGH: begin
                        if (w_fall) begin
                            r_hi_lat <= r_cnt;
                            r_state  <= ST_LOW;
                            r_cnt    <= w_cnt_inc;
                        end else if (w_limit) begin
                            r_stuck <= 1'b1;
                            r_state <= ST_ARM;
                            r_cnt   <= CNT_ZERO;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            // New result overrides any ack in the same cycle.
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_lat;
                            r_valid     <= 1'b1;
                            if (r_valid && !meas_ack) begin
                                r_overrun <= 1'b1;
                            end
                            r_cnt   <= CNT_ONE;
                            r_state <= ST_HIGH;
                        end else if (w_limit) begin
                            r_stuck <= 1'b1;
                            r_state <= ST_ARM;
                            r_cnt   <= CNT_ZERO;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_valid;
    assign overrun    = r_overrun;
    assign stuck      = r_stuck;

endmodule
